// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave
// AXI-Lite responder for a bank of NUM_REGS x DATA_W configuration/status
// registers. The write path latches AW and W independently, commits one write
// at a time and answers on B. The read path answers each AR on R with a
// registered beat. Register contents and per-register write strobes are
// exported to the datapath. Read-only registers return the ro_d status inputs.

module axi_lite_reg_slave #(
    parameter logic [3:0]          BLOCK_ID = 4'h1,
    parameter int                  NUM_REGS = 16,
    parameter int                  DATA_W   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [15:0]                AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    input  logic [15:0]                ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wr_pulse,
    input  logic [NUM_REGS*DATA_W-1:0] ro_d
);

    localparam int         IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NUM_REGS_LIM = 9'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    // An address hits when block, page and register index all fall inside this bank.
    function automatic logic addr_hit(input logic [15:0] a);
        return (a[15:12] == BLOCK_ID) && (a[11:8] == 4'h0) &&
               ({1'b0, a[7:0]} < NUM_REGS_LIM);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 ready_en_q;
    logic                 aw_held_q, aw_held_d;
    logic                 w_held_q,  w_held_d;
    logic [15:0]          awaddr_q,  awaddr_d;
    logic [DATA_W-1:0]    wdata_q,   wdata_d;
    logic                 commit_q,  commit_d;
    logic                 bvalid_q,  bvalid_d;
    logic [1:0]           bresp_q,   bresp_d;
    logic                 rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]    rdata_q,   rdata_d;
    logic [1:0]           rresp_q,   rresp_d;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]  pulse_q;
    logic [DATA_W-1:0]    ro_arr [NUM_REGS];

    logic                 aw_ready, w_ready, ar_ready;
    logic                 aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]     w_idx, r_idx;
    logic                 w_ok, do_write, r_hit;

    // Slice the flat status bus into one word per register.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
        assign ro_arr[g]                  = ro_d[g*DATA_W +: DATA_W];
        assign reg_q[g*DATA_W +: DATA_W]  = regs_q[g];
    end

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Address/data channels close while a write is held, committing or answered.
    assign aw_ready = ready_en_q & ~aw_held_q & ~bvalid_q & ~commit_q;
    assign w_ready  = ready_en_q & ~w_held_q  & ~bvalid_q & ~commit_q;
    assign ar_ready = ready_en_q & ~rvalid_q;

    assign aw_hs = AWVALID & aw_ready;
    assign w_hs  = WVALID  & w_ready;
    assign ar_hs = ARVALID & ar_ready;

    assign w_idx    = awaddr_q[IDX_W-1:0];
    assign w_ok     = addr_hit(awaddr_q) & ~RO_MASK[w_idx];
    assign do_write = commit_q & w_ok;

    assign r_idx = ARADDR[IDX_W-1:0];
    assign r_hit = addr_hit(ARADDR);

    // ------------------------------------------------------------------
    // Write channel next state
    // ------------------------------------------------------------------
    // Latch AW/W independently, arm the commit once both are held, then answer on B.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        commit_d  = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = WDATA;
        end

        if (aw_held_q && w_held_q && !commit_q) begin
            commit_d = 1'b1;
        end

        if (commit_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read channel next state
    // ------------------------------------------------------------------
    // Capture the read beat on AR; hold it until the master takes it.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (r_hit) begin
                rresp_d = RESP_OKAY;
                rdata_d = RO_MASK[r_idx] ? ro_arr[r_idx] : regs_q[r_idx];
            end else begin
                rresp_d = RESP_SLVERR;
                rdata_d = '0;
            end
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // READYs stay low in reset and open on the first edge afterwards.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            ready_en_q <= 1'b1;
        end
    end

    // Write channel registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            commit_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            commit_q  <= commit_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Read channel registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    // Register bank and one-cycle write strobes, updated on a successful commit.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            // NOTE: the bank is visible on reg_q, so every entry is reset rather than left as RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            if (do_write) begin
                regs_q[w_idx]  <= wdata_q;
                pulse_q[w_idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign AWREADY      = aw_ready;
    assign WREADY       = w_ready;
    assign BVALID       = bvalid_q;
    assign BRESP        = bresp_q;
    assign ARREADY      = ar_ready;
    assign RVALID       = rvalid_q;
    assign RDATA        = rdata_q;
    assign RRESP        = rresp_q;
    assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave
// Directed scenarios plus randomized traffic against a register-array model
// of axi_lite_reg_slave. Inputs change on the falling edge, outputs are
// sampled on the falling edge.

module tb_axi_lite_reg_slave;

    localparam int          NR = 16;
    localparam int          DW = 16;
    localparam logic [15:0] RO = 16'h8080;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [15:0]       AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DW-1:0]     WDATA;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [15:0]       ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [NR*DW-1:0]  reg_q;
    logic [NR-1:0]     reg_wr_pulse;
    logic [NR*DW-1:0]  ro_d;

    int total = 0;
    int bad   = 0;

    // Behavioural model: the register contents and status inputs.
    logic [15:0] m_regs [NR];
    logic [15:0] m_ro   [NR];

    axi_lite_reg_slave #(
        .BLOCK_ID (4'h1),
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .RO_MASK  (RO)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .AWADDR       (AWADDR),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WDATA        (WDATA),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .BRESP        (BRESP),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .ARADDR       (ARADDR),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .RDATA        (RDATA),
        .RRESP        (RRESP),
        .RVALID       (RVALID),
        .RREADY       (RREADY),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse),
        .ro_d         (ro_d)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic exp_hit(input logic [15:0] a);
        return (a[15:12] == 4'h1) && (a[11:8] == 4'h0) && (a[7:0] < 8'd16);
    endfunction

    function automatic logic [NR*DW-1:0] exp_regq();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
    endtask

    task automatic set_ro(input int i, input logic [15:0] v);
        ro_d[i*DW +: DW] = v;
        m_ro[i] = v;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel <= 6)      a = {8'h10, 4'h0, 4'($urandom_range(0, 15))};
        else if (sel == 7) a = {4'($urandom_range(2, 15)), 4'h0, 8'($urandom_range(0, 15))};
        else if (sel == 8) a = {8'h10, 8'($urandom_range(16, 255))};
        else               a = {4'h1, 4'($urandom_range(1, 15)), 8'($urandom_range(0, 15))};
        return a;
    endfunction

    // One write; lead > 0 sends W that many cycles before AW, lead < 0 the reverse.
    task automatic write_txn(input logic [15:0] addr, input logic [15:0] data,
                             input int lead, input int bdly);
        int          aw_s, w_s;
        logic        aw_pend, w_pend, done, ok;
        logic [1:0]  exp_resp;
        logic [NR-1:0] exp_pulse;
        aw_s      = (lead > 0) ? lead : 0;
        w_s       = (lead < 0) ? -lead : 0;
        ok        = exp_hit(addr) && !RO[addr[3:0]];
        exp_resp  = ok ? 2'b00 : 2'b10;
        exp_pulse = ok ? (NR'(1) << addr[3:0]) : '0;
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        done    = 1'b0;
        AWADDR  = addr;
        WDATA   = data;
        for (int t = 0; t < 50 && !done; t++) begin
            if (aw_pend && !w_pend) begin
                total++;
                if (WREADY !== 1'b0) begin
                    bad++; $display("FAIL wready_while_held got=%b exp=0", WREADY);
                end
            end
            if (w_pend && !aw_pend) begin
                total++;
                if (AWREADY !== 1'b0) begin
                    bad++; $display("FAIL awready_while_held got=%b exp=0", AWREADY);
                end
            end
            AWVALID = aw_pend && (t >= aw_s);
            WVALID  = w_pend && (t >= w_s);
            if (AWVALID && AWREADY) aw_pend = 1'b0;
            if (WVALID && WREADY)   w_pend  = 1'b0;
            @(negedge ACLK);
            done = !aw_pend && !w_pend;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        total++;
        if (!done) begin
            bad++; $display("FAIL write_handshake_timeout addr=%h", addr);
            return;
        end
        // One cycle after the last handshake: nothing visible yet.
        total++;
        if ({BVALID, reg_wr_pulse} !== '0) begin
            bad++; $display("FAIL b_early1 bvalid=%b pulse=%h exp=0", BVALID, reg_wr_pulse);
        end
        @(negedge ACLK);
        total++;
        if ({BVALID, reg_wr_pulse} !== '0) begin
            bad++; $display("FAIL b_early2 bvalid=%b pulse=%h exp=0", BVALID, reg_wr_pulse);
        end
        @(negedge ACLK);
        if (ok) m_regs[addr[3:0]] = data;
        total++;
        if (BVALID !== 1'b1) begin
            bad++; $display("FAIL b_latency addr=%h bvalid=%b exp=1", addr, BVALID);
            for (int k = 0; k < 20 && BVALID !== 1'b1; k++) @(negedge ACLK);
        end
        total++;
        if (BRESP !== exp_resp) begin
            bad++; $display("FAIL bresp addr=%h got=%b exp=%b", addr, BRESP, exp_resp);
        end
        total++;
        if (reg_wr_pulse !== exp_pulse) begin
            bad++; $display("FAIL wr_pulse addr=%h got=%h exp=%h", addr, reg_wr_pulse, exp_pulse);
        end
        total++;
        if (reg_q !== exp_regq()) begin
            bad++; $display("FAIL reg_q_after_write addr=%h got=%h exp=%h", addr, reg_q, exp_regq());
        end
        for (int k = 0; k < bdly; k++) begin
            @(negedge ACLK);
            total++;
            if (BVALID !== 1'b1 || BRESP !== exp_resp || reg_wr_pulse !== '0 || AWREADY !== 1'b0) begin
                bad++; $display("FAIL b_hold bvalid=%b bresp=%b pulse=%h awready=%b exp=1/%b/0/0",
                                BVALID, BRESP, reg_wr_pulse, AWREADY, exp_resp);
            end
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        total++;
        if (BVALID !== 1'b0 || reg_wr_pulse !== '0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
            bad++; $display("FAIL b_clear bvalid=%b pulse=%h awready=%b wready=%b exp=0/0/1/1",
                            BVALID, reg_wr_pulse, AWREADY, WREADY);
        end
    endtask

    task automatic read_txn(input logic [15:0] addr, input int rdly);
        logic [15:0] exp_data;
        logic [1:0]  exp_resp;
        logic        got;
        if (exp_hit(addr)) begin
            exp_data = RO[addr[3:0]] ? m_ro[addr[3:0]] : m_regs[addr[3:0]];
            exp_resp = 2'b00;
        end else begin
            exp_data = '0;
            exp_resp = 2'b10;
        end
        ARADDR  = addr;
        ARVALID = 1'b1;
        got     = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            if (ARREADY === 1'b1) got = 1'b1;
            else @(negedge ACLK);
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL ar_timeout addr=%h", addr);
            ARVALID = 1'b0;
            return;
        end
        @(negedge ACLK);
        ARVALID = 1'b0;
        total++;
        if (RVALID !== 1'b1 || RDATA !== exp_data || RRESP !== exp_resp) begin
            bad++; $display("FAIL read addr=%h got v=%b d=%h r=%b exp v=1 d=%h r=%b",
                            addr, RVALID, RDATA, RRESP, exp_data, exp_resp);
        end
        for (int k = 0; k < rdly; k++) begin
            @(negedge ACLK);
            total++;
            if (RVALID !== 1'b1 || RDATA !== exp_data || RRESP !== exp_resp || ARREADY !== 1'b0) begin
                bad++; $display("FAIL r_hold addr=%h v=%b d=%h r=%b arready=%b exp 1/%h/%b/0",
                                addr, RVALID, RDATA, RRESP, ARREADY, exp_data, exp_resp);
            end
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        total++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
            bad++; $display("FAIL r_clear rvalid=%b arready=%b exp=0/1", RVALID, ARREADY);
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; ro_d = '0;
        for (int i = 0; i < NR; i++) m_ro[i] = '0;
        clear_model();
        #1;
        total++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== '0 ||
            RDATA !== '0 || reg_q !== '0 || reg_wr_pulse !== '0) begin
            bad++; $display("FAIL reset_outputs ready=%b%b%b valid=%b%b rdata=%h regq=%h",
                            AWREADY, WREADY, ARREADY, BVALID, RVALID, RDATA, reg_q);
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        total++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            bad++; $display("FAIL ready_before_edge got=%b%b%b exp=000", AWREADY, WREADY, ARREADY);
        end
        @(negedge ACLK);
        total++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            bad++; $display("FAIL ready_after_edge got=%b%b%b exp=111", AWREADY, WREADY, ARREADY);
        end
    endtask

    task automatic test_same_cycle();
        total++;
        if ({AWREADY, WREADY} !== 2'b11) begin
            bad++; $display("FAIL same_cycle_ready got=%b%b exp=11", AWREADY, WREADY);
        end
        write_txn(16'h1003, 16'hBEEF, 0, 0);
    endtask

    task automatic test_w_first();
        write_txn(16'h1005, 16'h1234, 3, 1);
        write_txn(16'h1009, 16'h5A5A, -2, 0);
    endtask

    task automatic test_errors();
        write_txn(16'h2003, 16'hDEAD, 0, 0);
        write_txn(16'h1010, 16'hCAFE, 1, 0);
        write_txn(16'h1103, 16'hF00D, 0, 2);
        read_txn(16'h1010, 0);
    endtask

    task automatic test_read_hold();
        read_txn(16'h1003, 4);
    endtask

    task automatic test_read_only();
        set_ro(7, 16'h00A5);
        set_ro(15, 16'h7E57);
        read_txn(16'h1007, 1);
        write_txn(16'h1007, 16'h1111, 0, 0);
        read_txn(16'h1007, 0);
        read_txn(16'h100F, 0);
    endtask

    // Write commit and read handshake land on the same edge for register 2.
    task automatic test_concurrent();
        logic [15:0] old_v, new_v;
        old_v = m_regs[2];
        new_v = 16'h3C3C ^ old_v ^ 16'h0101;
        AWADDR = 16'h1002; WDATA = new_v; AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        ARADDR = 16'h1002; ARVALID = 1'b1;
        total++;
        if (ARREADY !== 1'b1) begin
            bad++; $display("FAIL conc_arready got=%b exp=1", ARREADY);
        end
        @(negedge ACLK);
        ARVALID = 1'b0;
        m_regs[2] = new_v;
        total++;
        if (RVALID !== 1'b1 || RDATA !== old_v || BVALID !== 1'b1 || reg_q !== exp_regq()) begin
            bad++; $display("FAIL conc_read rvalid=%b rdata=%h bvalid=%b exp 1/%h/1 regq=%h exp=%h",
                            RVALID, RDATA, BVALID, old_v, reg_q, exp_regq());
        end
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; RREADY = 1'b0;
        read_txn(16'h1002, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_ro(($urandom_range(0, 1) == 0) ? 7 : 15, 16'($urandom));
            end
            if ($urandom_range(0, 1) == 0) begin
                write_txn(rand_addr(), 16'($urandom), int'($urandom_range(0, 6)) - 3,
                          int'($urandom_range(0, 2)));
            end else begin
                read_txn(rand_addr(), int'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] v;
        v = 16'($urandom) | 16'h0001;
        AWADDR = 16'h1001; WDATA = v; AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        m_regs[1] = v;
        total++;
        if (BVALID !== 1'b1 || reg_q !== exp_regq()) begin
            bad++; $display("FAIL pre_reset_write bvalid=%b regq=%h exp=1/%h", BVALID, reg_q, exp_regq());
        end
        ARADDR = 16'h1001; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        total++;
        if (RVALID !== 1'b1) begin
            bad++; $display("FAIL pre_reset_read rvalid=%b exp=1", RVALID);
        end
        #2;
        ARESET = 1'b1;
        #1;
        clear_model();
        total++;
        if (BVALID !== 1'b0 || RVALID !== 1'b0 || reg_q !== '0 || RDATA !== '0 ||
            {AWREADY, WREADY, ARREADY} !== 3'b000) begin
            bad++; $display("FAIL async_reset bvalid=%b rvalid=%b regq=%h rdata=%h ready=%b%b%b exp all 0",
                            BVALID, RVALID, reg_q, RDATA, AWREADY, WREADY, ARREADY);
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        write_txn(16'h1001, 16'h4242, 0, 0);
        read_txn(16'h1001, 0);
        read_txn(16'h1003, 0);
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first();
        test_errors();
        test_read_hold();
        test_read_only();
        test_concurrent();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
